// File: rtl/fpu_unpack_pipe.sv
// fpu_unpack_pipe: two-stage IEEE-754 operand unpacker with valid/ready flow control.
// Stage 1 captures the raw fields, the class and the fraction leading-zero count.
// Stage 2 produces the unbiased exponent and the significand with explicit hidden bit.
module fpu_unpack_pipe #(
    parameter int EXPONENT_WIDTH       = 11,
    parameter int SIGNIFICAND_WIDTH    = 52,
    parameter int NORMALIZE_SUBNORMALS = 1,
    parameter int TAG_WIDTH            = 4
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    input  logic [EXPONENT_WIDTH+SIGNIFICAND_WIDTH:0]   in_fp,
    input  logic [TAG_WIDTH-1:0]                        in_tag,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic                                        out_sign,
    output logic [EXPONENT_WIDTH+1:0]                   out_exponent,
    output logic [SIGNIFICAND_WIDTH:0]                  out_significand,
    output logic [2:0]                                  out_class,
    output logic [TAG_WIDTH-1:0]                        out_tag
);

    localparam int EW   = EXPONENT_WIDTH;
    localparam int SW   = SIGNIFICAND_WIDTH;
    localparam int FW   = EW + SW + 1;
    localparam int XW   = EW + 2;
    localparam int LW   = $clog2(SW + 1);
    localparam int BIAS = (1 << (EW - 1)) - 1;

    // The most negative normalized subnormal exponent must be representable.
    if ((1 - BIAS - SW) < -(1 << (XW - 1))) begin : gExpRangeCheck
        $fatal(1, "fpu_unpack_pipe: exponent output too narrow for 1-bias-SW");
    end

    typedef enum logic [2:0] {
        CLS_ZERO      = 3'd0,
        CLS_SUBNORMAL = 3'd1,
        CLS_NORMAL    = 3'd2,
        CLS_INF       = 3'd3,
        CLS_QNAN      = 3'd4,
        CLS_SNAN      = 3'd5
    } fp_class_e;

    logic              inSign;
    logic [EW-1:0]     inExp;
    logic [SW-1:0]     inFrac;
    fp_class_e         class_d;
    logic [LW-1:0]     lzc_d;
    logic              lzcFound;

    logic              s1Valid_q;
    logic              s1Sign_q;
    logic [EW-1:0]     s1Exp_q;
    logic [SW-1:0]     s1Frac_q;
    fp_class_e         s1Class_q;
    logic [TAG_WIDTH-1:0] s1Tag_q;
    logic [LW-1:0]     s1Lzc_q;

    logic [XW-1:0]     exp_d;
    logic [SW:0]       sig_d;
    logic [LW:0]       shamt;

    logic              s2Valid_q;
    logic              s2Sign_q;
    logic [XW-1:0]     s2Exp_q;
    logic [SW:0]       s2Sig_q;
    fp_class_e         s2Class_q;
    logic [TAG_WIDTH-1:0] s2Tag_q;

    logic              rdy_q;
    logic              s2Adv;
    logic              s1Adv;
    logic              accept;

    assign inSign = in_fp[FW-1];
    assign inExp  = in_fp[SW +: EW];
    assign inFrac = in_fp[SW-1:0];

    // A stage advances when its downstream slot is free or is emptying this cycle.
    assign s2Adv    = !s2Valid_q || out_ready;
    assign s1Adv    = !s1Valid_q || s2Adv;
    assign in_ready = rdy_q && s1Adv;
    assign accept   = in_valid && in_ready;

    // Classify the incoming operand and count leading zeros of its fraction.
    always_comb begin
        class_d  = CLS_NORMAL;
        lzc_d    = LW'(SW);
        lzcFound = 1'b0;
        if (inExp == '0) begin
            class_d = (inFrac == '0) ? CLS_ZERO : CLS_SUBNORMAL;
        end else if (&inExp) begin
            if (inFrac == '0) begin
                class_d = CLS_INF;
            end else if (inFrac[SW-1]) begin
                class_d = CLS_QNAN;
            end else begin
                class_d = CLS_SNAN;
            end
        end
        for (int i = SW - 1; i >= 0; i--) begin
            if (!lzcFound && inFrac[i]) begin
                lzc_d    = LW'(SW - 1 - i);
                lzcFound = 1'b1;
            end
        end
    end

    // Stage 1 register: raw fields plus class and leading-zero count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1Valid_q <= 1'b0;
            s1Sign_q  <= 1'b0;
            s1Exp_q   <= '0;
            s1Frac_q  <= '0;
            s1Class_q <= CLS_ZERO;
            s1Tag_q   <= '0;
            s1Lzc_q   <= '0;
        end else if (s1Adv) begin
            s1Valid_q <= accept;
            if (accept) begin
                s1Sign_q  <= inSign;
                s1Exp_q   <= inExp;
                s1Frac_q  <= inFrac;
                s1Class_q <= class_d;
                s1Tag_q   <= in_tag;
                s1Lzc_q   <= lzc_d;
            end
        end
    end

    // Unbiased exponent and explicit-hidden-bit significand for each class.
    always_comb begin
        exp_d = '0;
        sig_d = '0;
        shamt = {1'b0, s1Lzc_q} + (LW + 1)'(1);
        case (s1Class_q)
            CLS_NORMAL: begin
                exp_d = {2'b00, s1Exp_q} - XW'(BIAS);
                sig_d = {1'b1, s1Frac_q};
            end
            CLS_SUBNORMAL: begin
                if (NORMALIZE_SUBNORMALS != 0) begin
                    exp_d = XW'(1 - BIAS) - XW'(shamt);
                    sig_d = {1'b0, s1Frac_q} << shamt;
                end else begin
                    exp_d = XW'(1 - BIAS);
                    sig_d = {1'b0, s1Frac_q};
                end
            end
            CLS_ZERO: begin
                exp_d = '0;
                sig_d = '0;
            end
            default: begin
                exp_d = XW'(BIAS + 1);
                sig_d = {1'b0, s1Frac_q};
            end
        endcase
    end

    // Stage 2 output register; holds its contents while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2Valid_q <= 1'b0;
            s2Sign_q  <= 1'b0;
            s2Exp_q   <= '0;
            s2Sig_q   <= '0;
            s2Class_q <= CLS_ZERO;
            s2Tag_q   <= '0;
        end else if (s2Adv) begin
            s2Valid_q <= s1Valid_q;
            if (s1Valid_q) begin
                s2Sign_q  <= s1Sign_q;
                s2Exp_q   <= exp_d;
                s2Sig_q   <= sig_d;
                s2Class_q <= s1Class_q;
                s2Tag_q   <= s1Tag_q;
            end
        end
    end

    // Input side opens one clock after reset is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
        end
    end

    assign out_valid       = s2Valid_q;
    assign out_sign        = s2Sign_q;
    assign out_exponent    = s2Exp_q;
    assign out_significand = s2Sig_q;
    assign out_class       = s2Class_q;
    assign out_tag         = s2Tag_q;

endmodule

// File: tb/tb_fpu_unpack_pipe.sv
// tb_fpu_unpack_pipe: randomized and directed bench with a behavioural unpack model.
module tb_fpu_unpack_pipe;

    typedef struct {
        logic        sign;
        longint      exp;
        logic [63:0] sig;
        int          cls;
    } expect_t;

    typedef struct packed {
        logic [63:0] fp;
        logic [3:0]  tag;
    } sbItem_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inValid;
    logic        outReady;
    logic [63:0] inFpA;
    logic [15:0] inFpC;
    logic [3:0]  inTag;

    logic        inReadyA, outValidA, outSignA;
    logic [12:0] outExpA;
    logic [52:0] outSigA;
    logic [2:0]  outClassA;
    logic [3:0]  outTagA;

    logic        inReadyB, outValidB, outSignB;
    logic [12:0] outExpB;
    logic [52:0] outSigB;
    logic [2:0]  outClassB;
    logic [3:0]  outTagB;

    logic        inReadyC, outValidC, outSignC;
    logic [6:0]  outExpC;
    logic [10:0] outSigC;
    logic [2:0]  outClassC;
    logic [3:0]  outTagC;

    int compared = 0;
    int failed   = 0;
    int cyc      = 0;
    int acceptCnt = 0;
    int emitCnt   = 0;

    sbItem_t     sbQ[$];
    logic [3:0]  emittedTags[$];

    logic        stallSaved = 1'b0;
    logic [52:0] savedSig;
    logic [20:0] savedMisc;

    fpu_unpack_pipe dutA (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(inReadyA),
        .in_fp(inFpA), .in_tag(inTag), .out_valid(outValidA), .out_ready(outReady),
        .out_sign(outSignA), .out_exponent(outExpA), .out_significand(outSigA),
        .out_class(outClassA), .out_tag(outTagA)
    );

    fpu_unpack_pipe #(.NORMALIZE_SUBNORMALS(0)) dutB (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(inReadyB),
        .in_fp(inFpA), .in_tag(inTag), .out_valid(outValidB), .out_ready(outReady),
        .out_sign(outSignB), .out_exponent(outExpB), .out_significand(outSigB),
        .out_class(outClassB), .out_tag(outTagB)
    );

    fpu_unpack_pipe #(.EXPONENT_WIDTH(5), .SIGNIFICAND_WIDTH(10)) dutC (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(inReadyC),
        .in_fp(inFpC), .in_tag(inTag), .out_valid(outValidC), .out_ready(outReady),
        .out_sign(outSignC), .out_exponent(outExpC), .out_significand(outSigC),
        .out_class(outClassC), .out_tag(outTagC)
    );

    always #5 clk = ~clk;

    // Free-running cycle counter used to schedule backpressure windows.
    always @(posedge clk) cyc++;

    // Behavioural unpack: field arithmetic straight from the IEEE-754 rules.
    function automatic expect_t refModel(input logic [63:0] bits, input int ew,
                                         input int sw, input int norm);
        expect_t     r;
        logic [63:0] f, e, allOnes;
        longint      bias;
        int          p, shift;
        f       = bits & ((64'd1 << sw) - 64'd1);
        e       = (bits >> sw) & ((64'd1 << ew) - 64'd1);
        allOnes = (64'd1 << ew) - 64'd1;
        bias    = (longint'(1) << (ew - 1)) - 1;
        r.sign  = bits[ew + sw];
        r.exp   = 0;
        r.sig   = 64'd0;
        r.cls   = 2;
        if (e == 64'd0 && f == 64'd0) begin
            r.cls = 0;
        end else if (e == 64'd0) begin
            r.cls = 1;
            if (norm != 0) begin
                p = 0;
                for (int i = 0; i < sw; i++) if (f[i]) p = i;
                shift = sw - p;
                r.sig = f << shift;
                r.exp = 1 - bias - shift;
            end else begin
                r.sig = f;
                r.exp = 1 - bias;
            end
        end else if (e == allOnes) begin
            r.cls = (f == 64'd0) ? 3 : (f[sw - 1] ? 4 : 5);
            r.exp = bias + 1;
            r.sig = f;
        end else begin
            r.exp = longint'(e) - bias;
            r.sig = f | (64'd1 << sw);
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [63:0] randOperand();
        logic [63:0] frac;
        logic [10:0] ex;
        int          sel;
        sel  = int'($urandom_range(0, 7));
        frac = {$urandom, $urandom} & 64'h000F_FFFF_FFFF_FFFF;
        case (sel)
            0: begin ex = 11'd0; frac = 64'd0; end
            1: begin
                ex   = 11'd0;
                frac = frac >> $urandom_range(0, 51);
                if (frac == 64'd0) frac = 64'd1;
            end
            2: begin ex = 11'h7FF; frac = 64'd0; end
            3: begin ex = 11'h7FF; if (frac == 64'd0) frac = 64'd1; end
            default: ex = 11'($urandom_range(1, 2046));
        endcase
        return {$urandom_range(0, 1) != 0, ex, frac[51:0]};
    endfunction

    // Scoreboard and stall-stability monitor for the double-precision unit.
    always @(negedge clk) begin
        sbItem_t item;
        expect_t r;
        if (!rst_n) begin
            sbQ.delete();
            stallSaved = 1'b0;
        end else begin
            if (stallSaved) begin
                checkOutput("stall valid held", 64'(outValidA), 64'd1);
                checkOutput("stall sig held", 64'(outSigA), 64'(savedSig));
                checkOutput("stall fields held",
                            64'({outSignA, outExpA, outClassA, outTagA}), 64'(savedMisc));
            end
            if (inValid && inReadyA) begin
                sbQ.push_back('{fp: inFpA, tag: inTag});
                acceptCnt++;
            end
            if (outValidA && outReady) begin
                emitCnt++;
                emittedTags.push_back(outTagA);
                if (sbQ.size() == 0) begin
                    checkOutput("unexpected output", 64'd1, 64'd0);
                end else begin
                    item = sbQ.pop_front();
                    r = refModel(item.fp, 11, 52, 1);
                    checkOutput("A tag", 64'(outTagA), 64'(item.tag));
                    checkOutput("A sign", 64'(outSignA), 64'(r.sign));
                    checkOutput("A exponent", 64'(longint'($signed(outExpA))), 64'(r.exp));
                    checkOutput("A significand", 64'(outSigA), r.sig);
                    checkOutput("A class", 64'(outClassA), 64'(r.cls));
                end
            end
            stallSaved = outValidA && !outReady;
            savedSig   = outSigA;
            savedMisc  = {outSignA, outExpA, outClassA, outTagA};
        end
    end

    // One operand through all three units with the consumer always ready.
    task automatic applyStimulus(input logic [63:0] fpD, input logic [15:0] fpH,
                                 input logic [3:0] tag);
        expect_t rB, rC, rA;
        inValid = 1'b1;
        inFpA   = fpD;
        inFpC   = fpH;
        inTag   = tag;
        @(negedge clk);
        checkOutput("directed in_ready", 64'(inReadyA), 64'd1);
        @(posedge clk);
        #1 inValid = 1'b0;
        @(negedge clk);
        checkOutput("out_valid after accept edge", 64'(outValidA), 64'd0);
        @(negedge clk);
        rA = refModel(fpD, 11, 52, 1);
        rB = refModel(fpD, 11, 52, 0);
        rC = refModel(64'(fpH), 5, 10, 1);
        checkOutput("A out_valid at latency", 64'(outValidA), 64'd1);
        checkOutput("A direct sig", 64'(outSigA), rA.sig);
        checkOutput("B out_valid", 64'(outValidB), 64'd1);
        checkOutput("B sign", 64'(outSignB), 64'(rB.sign));
        checkOutput("B exponent", 64'(longint'($signed(outExpB))), 64'(rB.exp));
        checkOutput("B significand", 64'(outSigB), rB.sig);
        checkOutput("B class", 64'(outClassB), 64'(rB.cls));
        checkOutput("C out_valid", 64'(outValidC), 64'd1);
        checkOutput("C sign", 64'(outSignC), 64'(rC.sign));
        checkOutput("C exponent", 64'(longint'($signed(outExpC))), 64'(rC.exp));
        checkOutput("C significand", 64'(outSigC), rC.sig);
        checkOutput("C class", 64'(outClassC), 64'(rC.cls));
        checkOutput("C tag", 64'(outTagC), 64'(tag));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        inValid  = 1'b0;
        outReady = 1'b1;
        n = 0;
        while ((sbQ.size() != 0 || outValidA) && n < 20) begin
            @(posedge clk);
            #1 n++;
        end
        checkOutput("drain leftover items", 64'(sbQ.size()), 64'd0);
    endtask

    task automatic pinModel();
        expect_t r;
        r = refModel(64'h3FF0_0000_0000_0000, 11, 52, 1);
        checkOutput("pin 1.0 exp", 64'(r.exp), 64'd0);
        checkOutput("pin 1.0 sig", r.sig, 64'h0010_0000_0000_0000);
        checkOutput("pin 1.0 class", 64'(r.cls), 64'd2);
        r = refModel(64'h1, 11, 52, 1);
        checkOutput("pin minsub exp", 64'(r.exp), 64'(longint'(-1074)));
        checkOutput("pin minsub sig", r.sig, 64'h0010_0000_0000_0000);
        checkOutput("pin minsub class", 64'(r.cls), 64'd1);
        r = refModel(64'h1, 11, 52, 0);
        checkOutput("pin minsub raw exp", 64'(r.exp), 64'(longint'(-1022)));
        checkOutput("pin minsub raw sig", r.sig, 64'h1);
        r = refModel(64'h8000_0000_0000_0000, 11, 52, 1);
        checkOutput("pin -0 sign", 64'(r.sign), 64'd1);
        checkOutput("pin -0 class", 64'(r.cls), 64'd0);
        r = refModel(64'h7FF0_0000_0000_0000, 11, 52, 1);
        checkOutput("pin inf class", 64'(r.cls), 64'd3);
        checkOutput("pin inf exp", 64'(r.exp), 64'd1024);
        r = refModel(64'h7FF8_0000_0000_0000, 11, 52, 1);
        checkOutput("pin qnan class", 64'(r.cls), 64'd4);
        r = refModel(64'h7FF0_0000_0000_0001, 11, 52, 1);
        checkOutput("pin snan class", 64'(r.cls), 64'd5);
        checkOutput("pin snan sig", r.sig, 64'h1);
        r = refModel(64'h0001, 5, 10, 1);
        checkOutput("pin half sub exp", 64'(r.exp), 64'(longint'(-24)));
        checkOutput("pin half sub sig", r.sig, 64'h400);
        r = refModel(64'h3C00, 5, 10, 1);
        checkOutput("pin half 1.0 exp", 64'(r.exp), 64'd0);
        checkOutput("pin half 1.0 sig", r.sig, 64'h400);
    endtask

    // Tags 0..7 back to back with the consumer stalled for three cycles.
    task automatic backpressureTest();
        int  start, idx, rel;
        logic acc, sawDrop;
        emittedTags.delete();
        start   = cyc;
        idx     = 0;
        sawDrop = 1'b0;
        while (idx < 8 && (cyc - start) < 100) begin
            rel      = cyc - start;
            outReady = !(rel >= 3 && rel <= 5);
            inValid  = 1'b1;
            inTag    = 4'(idx);
            inFpA    = randOperand();
            @(negedge clk);
            if (!inReadyA && !sawDrop) begin
                sawDrop = 1'b1;
                checkOutput("items held at in_ready drop", 64'(acceptCnt - emitCnt), 64'd2);
            end
            acc = inReadyA;
            @(posedge clk);
            #1;
            if (acc) idx++;
        end
        checkOutput("backpressure accepted all", 64'(idx), 64'd8);
        checkOutput("in_ready dropped under stall", 64'(sawDrop), 64'd1);
        drain();
        checkOutput("tags emitted count", 64'(emittedTags.size()), 64'd8);
        for (int i = 0; i < 8 && i < emittedTags.size(); i++) begin
            checkOutput("tag order", 64'(emittedTags[i]), 64'(i));
        end
    endtask

    // Fill both stages, pulse reset, then confirm a clean restart.
    task automatic resetMidStream();
        int n, got;
        outReady = 1'b0;
        got = 0;
        n   = 0;
        while (got < 2 && n < 20) begin
            inValid = 1'b1;
            inTag   = 4'(got + 9);
            inFpA   = randOperand();
            @(negedge clk);
            if (inReadyA) got++;
            @(posedge clk);
            #1 n++;
        end
        inValid = 1'b0;
        @(negedge clk);
        checkOutput("full before reset out_valid", 64'(outValidA), 64'd1);
        checkOutput("full before reset in_ready", 64'(inReadyA), 64'd0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset pulse out_valid", 64'(outValidA), 64'd0);
        checkOutput("reset pulse in_ready", 64'(inReadyA), 64'd0);
        checkOutput("reset pulse sig", 64'(outSigA), 64'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        checkOutput("in_ready before first edge", 64'(inReadyA), 64'd0);
        outReady = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("in_ready after first edge", 64'(inReadyA), 64'd1);
        applyStimulus(64'h3FF0_0000_0000_0000, 16'h3C00, 4'd3);
    endtask

    // Watchdog: stop with a failure line if the run never finishes.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    logic [63:0] dirD[8];
    logic [15:0] dirH[8];

    initial begin
        dirD = '{64'h3FF0_0000_0000_0000, 64'h0000_0000_0000_0001,
                 64'h8000_0000_0000_0000, 64'h7FF0_0000_0000_0000,
                 64'h7FF8_0000_0000_0000, 64'h7FF0_0000_0000_0001,
                 64'h000F_FFFF_FFFF_FFFF, 64'hC009_21FB_5444_2D18};
        dirH = '{16'h0001, 16'h3C00, 16'h8000, 16'h7C00,
                 16'h7E00, 16'h7C01, 16'h03FF, 16'hC248};
        rst_n    = 1'b0;
        inValid  = 1'b0;
        outReady = 1'b0;
        inFpA    = '0;
        inFpC    = '0;
        inTag    = '0;
        #3;
        checkOutput("reset out_valid", 64'(outValidA), 64'd0);
        checkOutput("reset in_ready", 64'(inReadyA), 64'd0);
        checkOutput("reset exponent", 64'(outExpA), 64'd0);
        checkOutput("reset significand", 64'(outSigA), 64'd0);
        checkOutput("reset class/tag", 64'({outClassA, outTagA, outSignA}), 64'd0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        checkOutput("in_ready held after release", 64'(inReadyA), 64'd0);
        outReady = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("in_ready one cycle after release", 64'(inReadyA), 64'd1);

        pinModel();

        for (int i = 0; i < 8; i++) begin
            applyStimulus(dirD[i], dirH[i], 4'(i));
        end

        backpressureTest();
        resetMidStream();
        drain();

        for (int i = 0; i < 3000; i++) begin
            inValid  = ($urandom_range(0, 3) != 0);
            outReady = ($urandom_range(0, 3) != 0);
            inFpA    = randOperand();
            inFpC    = 16'($urandom);
            inTag    = 4'($urandom);
            @(posedge clk);
            #1;
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
